// File: rtl/shifter_operand_unit_pkg.sv
// shifter_operand_unit_pkg: shared shift-type/mode enums and width default for the operand-2 shifter.
package shifter_operand_unit_pkg;
    localparam int DATA_W_DEF = 32;
    typedef enum logic [1:0] {SH_LSL = 2'b00, SH_LSR = 2'b01, SH_ASR = 2'b10, SH_ROR = 2'b11} shift_t;
    typedef enum logic [1:0] {MODE_MEM, MODE_IMM, MODE_REG, MODE_ISH} mode_t;
endpackage

// File: rtl/shifter_operand_unit_barrel_shifter.sv
// barrel_shifter: combinational register-shift semantics (amounts >= DATA_W saturate) plus optional RRX.
module barrel_shifter
    import shifter_operand_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AMT_W  = 8
) (
    input  logic [DATA_W-1:0] data_i,
    input  shift_t            type_i,
    input  logic [AMT_W-1:0]  amt_i,
    input  logic              carry_i,
    input  logic              rrx_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o
);
    localparam int LW = $clog2(DATA_W);
    logic [DATA_W:0]   lsl_w, lsr_w, asr_w;
    logic [DATA_W-1:0] ror_w;
    // One guard bit beside the data catches the last bit shifted out, including n==DATA_W.
    assign lsl_w = {1'b0, data_i} << amt_i;
    assign lsr_w = {data_i, 1'b0} >> amt_i;
    assign asr_w = $signed({data_i, 1'b0}) >>> amt_i;
    assign ror_w = DATA_W'({data_i, data_i} >> amt_i[LW-1:0]);
    always_comb begin
        {carry_o, result_o} = {carry_i, data_i};
        if (rrx_i)
            {carry_o, result_o} = {data_i[0], carry_i, data_i[DATA_W-1:1]};
        else if (amt_i != '0)
            case (type_i)
                SH_LSL:  {carry_o, result_o} = lsl_w;
                SH_LSR:  {result_o, carry_o} = lsr_w;
                SH_ASR:  {result_o, carry_o} = asr_w;
                default: {carry_o, result_o} = {ror_w[DATA_W-1], ror_w};
            endcase
    end
endmodule

// File: rtl/shifter_operand_unit.sv
// shifter_operand_unit: two-stage operand-2 shifter (decode/register in S1, shift in S2) with valid/ready.
// SHIFTER_RRX_EN: when defined, immediate ROR #0 performs RRX instead of passing rm through.
module shifter_operand_unit
    import shifter_operand_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AMT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] rm,
    input  logic [DATA_W-1:0] rs,
    input  logic [11:0]       shift_operand,
    input  logic              imm,
    input  logic              mem_sel,
    input  logic              reg_shift,
    input  logic              carry_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] val_2,
    output logic              carry_out
);
    mode_t             mode_d, s1_mode_q;
    shift_t            type_d, s1_type_q, so_type;
    logic [AMT_W-1:0]  amt_d, s1_amt_q;
    logic [DATA_W-1:0] opnd_d, s1_opnd_q, sh_res, val_2_d, val_2_q;
    logic              s1_valid_q, s1_carry_q, s2_valid_q, carry_q, carry_d, sh_c, s2_ready, rrx;
    logic              unused_rs;
    assign unused_rs = ^rs[DATA_W-1:AMT_W];
    assign so_type  = shift_t'(shift_operand[6:5]);
    assign s2_ready = !s2_valid_q || out_ready;
    assign in_ready = !flush && (!s1_valid_q || s2_ready);
    always_comb begin
        mode_d = mem_sel ? MODE_MEM : imm ? MODE_IMM : reg_shift ? MODE_REG : MODE_ISH;
        type_d = mem_sel ? SH_LSL : imm ? SH_ROR : so_type;
        // Immediate LSR/ASR #0 encodes a full-width shift.
        amt_d  = mem_sel ? '0 : imm ? AMT_W'({shift_operand[11:8], 1'b0}) : reg_shift ? rs[AMT_W-1:0] :
                 (shift_operand[11:7] == '0 && (so_type == SH_LSR || so_type == SH_ASR)) ? AMT_W'(DATA_W) :
                 AMT_W'(shift_operand[11:7]);
        opnd_d = mem_sel ? DATA_W'(shift_operand) : imm ? DATA_W'(shift_operand[7:0]) : rm;
    end
`ifdef SHIFTER_RRX_EN
    assign rrx = s1_mode_q == MODE_ISH && s1_type_q == SH_ROR && s1_amt_q == '0;
`else
    assign rrx = 1'b0;
`endif
    barrel_shifter #(.DATA_W(DATA_W), .AMT_W(AMT_W)) u_shifter (
        .data_i  (s1_opnd_q),
        .type_i  (s1_type_q),
        .amt_i   (s1_amt_q),
        .carry_i (s1_carry_q),
        .rrx_i   (rrx),
        .result_o(sh_res),
        .carry_o (sh_c)
    );
    assign val_2_d = (s1_mode_q == MODE_MEM) ? s1_opnd_q : sh_res;
    assign carry_d = (s1_mode_q == MODE_MEM) ? s1_carry_q : sh_c;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= MODE_MEM;
            s1_type_q  <= SH_LSL;
            s1_amt_q   <= '0;
            s1_opnd_q  <= '0;
            s1_carry_q <= 1'b0;
            s2_valid_q <= 1'b0;
            val_2_q    <= '0;
            carry_q    <= 1'b0;
        end else begin
            if (flush)
                s1_valid_q <= 1'b0;
            else if (!s1_valid_q || s2_ready)
                s1_valid_q <= in_valid;
            if (in_valid && in_ready) begin
                s1_mode_q  <= mode_d;
                s1_type_q  <= type_d;
                s1_amt_q   <= amt_d;
                s1_opnd_q  <= opnd_d;
                s1_carry_q <= carry_in;
            end
            if (flush)
                s2_valid_q <= 1'b0;
            else if (s2_ready)
                s2_valid_q <= s1_valid_q;
            if (!flush && s2_ready && s1_valid_q) begin
                val_2_q <= val_2_d;
                carry_q <= carry_d;
            end
        end
    end
    assign out_valid = s2_valid_q;
    assign val_2     = val_2_q;
    assign carry_out = carry_q;
endmodule

// File: tb/tb_shifter_operand_unit.sv
// tb_shifter_operand_unit: randomized scoreboard bench with an iterative bit-at-a-time shift model.
module tb_shifter_operand_unit;
    localparam int W = 32;
    logic clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 1;
    logic imm = 0, mem_sel = 0, reg_shift = 0, carry_in = 0;
    logic [W-1:0] rm = 0, rs = 0, val_2;
    logic [11:0] so = 0;
    logic in_ready, out_valid, carry_out;
    logic v64 = 0;
    logic [63:0] rm64 = 0, rs64 = 0, val64;
    logic in_ready64, out_valid64, carry64;
    int tests = 0, fails = 0, delivered = 0;
    logic [W:0] q[$];

    shifter_operand_unit #(.DATA_W(W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .rm(rm), .rs(rs), .shift_operand(so), .imm(imm), .mem_sel(mem_sel),
        .reg_shift(reg_shift), .carry_in(carry_in), .out_valid(out_valid),
        .out_ready(out_ready), .val_2(val_2), .carry_out(carry_out)
    );

    shifter_operand_unit #(.DATA_W(64)) dut64 (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(v64), .in_ready(in_ready64),
        .rm(rm64), .rs(rs64), .shift_operand(12'h000), .imm(1'b0), .mem_sel(1'b0),
        .reg_shift(1'b1), .carry_in(1'b0), .out_valid(out_valid64),
        .out_ready(1'b1), .val_2(val64), .carry_out(carry64)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Shifts one bit position per step; carry is whatever bit fell off last.
    function automatic logic [W:0] model(input logic [11:0] s, input logic im, input logic ms,
                                         input logic rg, input logic ci, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        logic [W-1:0] v;
        logic c;
        logic [1:0] t;
        int n;
        if (ms) return {ci, {(W-12){1'b0}}, s};
        if (im) begin
            v = {{(W-8){1'b0}}, s[7:0]};
            n = 2 * s[11:8];
            for (int i = 0; i < n; i++) v = {v[0], v[W-1:1]};
            return {(n == 0) ? ci : v[W-1], v};
        end
        t = s[6:5];
        v = a;
        c = ci;
        if (rg) n = int'(b[7:0]);
        else begin
            n = int'(s[11:7]);
            if (n == 0 && (t == 2'b01 || t == 2'b10)) n = W;
`ifdef SHIFTER_RRX_EN
            if (n == 0 && t == 2'b11) return {a[0], ci, a[W-1:1]};
`endif
        end
        for (int i = 0; i < n; i++)
            case (t)
                2'b00:   begin c = v[W-1]; v = v << 1; end
                2'b01:   begin c = v[0]; v = v >> 1; end
                2'b10:   begin c = v[0]; v = {v[W-1], v[W-1:1]}; end
                default: begin c = v[0]; v = {v[0], v[W-1:1]}; end
            endcase
        return {c, v};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("in_ready", in_ready, !flush && (q.size() < 2 || out_ready));
            if (q.size() != 1) chk("out_valid", out_valid, q.size() == 2);
            if (out_valid && q.size() > 0) begin
                chk("val_2", val_2, q[0][W-1:0]);
                chk("carry_out", carry_out, q[0][W]);
                if (out_ready) begin
                    void'(q.pop_front());
                    delivered++;
                end
            end
            if (flush) q.delete();
            else if (in_valid && in_ready) q.push_back(model(so, imm, mem_sel, reg_shift, carry_in, rm, rs));
        end
    end

    task automatic drive(input logic [11:0] s, input logic im, input logic ms, input logic rg,
                         input logic ci, input logic [W-1:0] a, input logic [W-1:0] b);
        so = s; imm = im; mem_sel = ms; reg_shift = rg; carry_in = ci; rm = a; rs = b;
        in_valid = 1;
    endtask

    task automatic send(input logic [11:0] s, input logic im, input logic ms, input logic rg,
                        input logic ci, input logic [W-1:0] a, input logic [W-1:0] b);
        drive(s, im, ms, rg, ci, a, b);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic lit(input string name, input logic [W-1:0] ev, input logic ec);
        @(posedge clk); #1;
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_val"}, val_2, ev);
        chk({name, "_carry"}, carry_out, ec);
    endtask

    task automatic drain(input string name);
        int k = 0;
        in_valid = 0; flush = 0; out_ready = 1;
        while (q.size() != 0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk(name, q.size(), 0);
    endtask

    initial begin
        logic [7:0] amts[8] = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'd64, 8'd200, 8'd255};
        int d0;
        logic saw, acc;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_val_2", val_2, 0);
        chk("rst_carry", carry_out, 0);
        rst = 1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("model_imm", model(12'h4FF, 1, 0, 0, 0, 0, 0), {1'b1, 32'hFF000000});
        chk("model_lsl33", model(12'h000, 0, 0, 1, 1, 32'h80000001, 33), 0);
        chk("model_asr0", model(12'h040, 0, 0, 0, 0, 32'h80000000, 0), {1'b1, 32'hFFFFFFFF});
        @(posedge clk); #1;

        send(12'h4FF, 1, 0, 0, 0, 0, 0);                   lit("imm_rot4", 32'hFF000000, 1);
        send(12'h000, 0, 0, 1, 0, 32'h80000001, 32);       lit("reg_lsl32", 0, 1);
        send(12'h000, 0, 0, 1, 1, 32'h80000001, 33);       lit("reg_lsl33", 0, 0);
        send(12'h040, 0, 0, 0, 0, 32'h80000000, 0);        lit("ish_asr0", 32'hFFFFFFFF, 1);
`ifdef SHIFTER_RRX_EN
        send(12'h060, 0, 0, 0, 1, 32'h3, 0);               lit("ish_rrx", 32'h80000001, 1);
`else
        send(12'h060, 0, 0, 0, 1, 32'h3, 0);               lit("ish_ror0", 32'h3, 1);
`endif
        send(12'hABC, 1, 1, 1, 1, 32'h5, 0);               lit("mem_sel", 32'h00000ABC, 1);
        send(12'h060, 0, 0, 1, 0, 32'h80000001, 32);       lit("reg_ror32", 32'h80000001, 1);
        send(12'h040, 0, 0, 1, 1, 32'h7FFFFFFF, 40);       lit("reg_asr40", 0, 0);
        send(12'h200, 0, 0, 0, 0, 32'hF0000001, 0);        lit("ish_lsl4", 32'h00000010, 1);
        send(12'h0A0, 0, 0, 0, 0, 32'h3, 0);               lit("ish_lsr1", 32'h1, 1);
        send(12'h000, 0, 0, 1, 1, 32'h12345678, 32'h100);  lit("reg_n0", 32'h12345678, 1);
        drain("drain_directed");

        d0 = delivered; saw = 0;
        for (int cyc = 0, idx = 0; cyc < 14; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            if (idx < 4) drive(12'h000, 0, 0, 1, 0, 32'h11 << idx, idx + 1);
            else in_valid = 0;
            @(negedge clk);
            acc = in_valid && in_ready;
            if (!in_ready) saw = 1;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        drain("drain_stall");
        chk("stall_delivered", delivered - d0, 4);
        chk("stall_ready_drop", saw, 1);

        out_ready = 0;
        send(12'h000, 0, 1, 0, 1, 0, 0);
        send(12'h123, 0, 1, 0, 0, 0, 0);
        flush = 1;
        drive(12'h456, 0, 1, 0, 0, 0, 0);
        @(posedge clk); #1;
        flush = 0; in_valid = 0; out_ready = 1;
        chk("flush_out_valid", out_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("flush_quiet", out_valid, 0);

        for (int i = 0; i < 500; i++) begin
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 39) == 0;
            mem_sel = $urandom_range(0, 7) == 0;
            imm = $urandom_range(0, 3) == 0;
            reg_shift = $urandom_range(0, 1) == 1;
            carry_in = $urandom_range(0, 1) == 1;
            so = 12'($urandom);
            if ($urandom_range(0, 3) == 0) so[11:7] = 0;
            rm = $urandom;
            rs = $urandom;
            if ($urandom_range(0, 3) != 0) rs[7:0] = amts[$urandom_range(0, 7)];
            @(posedge clk); #1;
        end
        drain("drain_random");

        out_ready = 1;
        send(12'hFFF, 0, 1, 0, 1, 0, 0);
        drive(12'hFFE, 0, 1, 0, 1, 0, 0);
        @(posedge clk); #2;
        rst = 0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_val", val_2, 0);
        chk("async_rst_carry", carry_out, 0);
        q.delete();
        in_valid = 0;
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk("rst_release_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("rst_no_output", out_valid, 0);

        rm64 = 64'h8000000000000001; rs64 = 64; v64 = 1;
        @(posedge clk); #1;
        v64 = 0;
        @(posedge clk); #1;
        chk("w64_lsl64_valid", out_valid64, 1);
        chk("w64_lsl64_val", val64, 0);
        chk("w64_lsl64_carry", carry64, 1);
        rs64 = 65; v64 = 1;
        @(posedge clk); #1;
        v64 = 0;
        @(posedge clk); #1;
        chk("w64_lsl65_val", val64, 0);
        chk("w64_lsl65_carry", carry64, 0);
        rs64 = 63; v64 = 1;
        @(posedge clk); #1;
        v64 = 0;
        @(posedge clk); #1;
        chk("w64_lsl63_val", val64, 64'h8000000000000000);
        chk("w64_lsl63_carry", carry64, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/shifter_operand_unit.md
SHIFTER_OPERAND_UNIT -- requirements
Module: shifter_operand_unit

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; SHALL be a power of two, 16..64.
REQ-002 Parameter AMT_W, default 8, register-shift amount bits taken from rs[AMT_W-1:0].
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous pipeline kill.
REQ-006 in_valid / in_ready  input / output  1 / 1  request handshake.
REQ-007 rm, rs  input  DATA_W each  operand and shift-amount register values.
REQ-008 shift_operand  input  12  {rotate_imm[11:8], imm8[7:0]} or {shift_imm[11:7], type[6:5], reg_flag[4], rm_idx[3:0]}.
REQ-009 imm, mem_sel, reg_shift, carry_in  input  1 each  mode selects and current C flag.
REQ-010 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-011 val_2  output  DATA_W  operand-2 result; carry_out  output  1  shifter carry.

Function
REQ-012 Two-stage pipeline: S1 registers decoded mode, type, amount (8 bits) and operands; S2 registers val_2/carry_out; latency exactly 2 cycles with out_ready held high.
REQ-013 Transfer occurs on valid&&ready at each boundary; in_ready SHALL equal !s1_valid || (!s2_valid || out_ready); S2 holds val_2, carry_out, out_valid stable while out_valid && !out_ready.
REQ-014 Full throughput: one result per cycle when out_ready stays high; no bubble inserted.
REQ-015 Mode priority: mem_sel > imm > reg_shift > immediate shift.
REQ-016 mem_sel: val_2 = zero-extended shift_operand; carry_out = carry_in.
REQ-017 imm: val_2 = zero-extended imm8 rotated right by (2*rotate_imm) mod DATA_W; carry_out = carry_in if rotate_imm==0 else val_2[DATA_W-1].
REQ-018 Immediate shift, amount = shift_imm: LSL logical left; LSR logical right; ASR sign-filling right; ROR rotate; LSR/ASR with shift_imm==0 SHALL shift by DATA_W; LSL #0 passes rm, carry_out = carry_in.
REQ-019 Register shift, amount n = rs[AMT_W-1:0]: n==0 -> val_2 = rm, carry_out = carry_in for all types.
REQ-020 LSL/LSR: n<DATA_W normal shift, carry = last bit out; n==DATA_W -> 0, carry = rm[0] (LSL) / rm[DATA_W-1] (LSR); n>DATA_W -> 0, carry 0.
REQ-021 ASR with n>=DATA_W -> all bits rm[DATA_W-1], carry = rm[DATA_W-1].
REQ-022 ROR: effective n mod DATA_W; if that is 0 (n nonzero) val_2 = rm, carry = rm[DATA_W-1]; else carry = val_2[DATA_W-1].
REQ-023 flush SHALL clear s1_valid and s2_valid next edge, discarding any accepted-but-undelivered request; an in_valid in the flush cycle is not accepted (in_ready forced 0).
REQ-024 Simultaneous S2 drain and S1 advance in one cycle SHALL not lose or duplicate a request.

Reset
REQ-025 While rst low: s1_valid, s2_valid, out_valid = 0; val_2 = 0; carry_out = 0; in_ready = 1 after release.
REQ-026 Reset asserted mid-operation SHALL abort all in-flight requests immediately (asynchronous), no output produced for them.

Configuration
REQ-027 Macro SHIFTER_RRX_EN: defined -> immediate ROR with shift_imm==0 is RRX: val_2 = {carry_in, rm[DATA_W-1:1]}, carry_out = rm[0]; undefined -> that encoding passes rm, carry_out = carry_in.

Structure
REQ-028 Shared package holds shift-type enum (LSL=00, LSR=01, ASR=10, ROR=11), mode enum, and DATA_W default constant.
REQ-029 One sub-module, barrel_shifter (combinational, DATA_W parametrised, returns result and carry), instantiated in S2.

Verification
REQ-030 imm=1, shift_operand=0x4FF, carry_in=0 -> after 2 cycles val_2=0xFF000000, carry_out=1.
REQ-031 reg_shift LSL, rm=0x80000001, rs=32 -> val_2=0, carry_out=1; rs=33 -> val_2=0, carry_out=0.
REQ-032 Immediate ASR shift_imm=0, rm=0x80000000 -> val_2=0xFFFFFFFF, carry_out=1; ROR #0, carry_in=1, rm=0x3: with SHIFTER_RRX_EN val_2=0x80000001, carry_out=1; without val_2=0x3.
REQ-033 Back-to-back 4 requests, out_ready low cycles 3-5 -> results delivered in order, each exactly once, outputs stable during stall, in_ready drops when both stages full.
REQ-034 flush with two requests in flight -> out_valid=0 next cycle; rst pulsed mid-stream -> all outputs zero asynchronously; DATA_W=64 rerun of REQ-031 with rs=64/65.
